// File: rtl/dot_product_engine.sv
// dot_product_engine: streams signed weight/activation pairs through a
// two-stage multiply/accumulate pipeline, adds a bias and returns one
// saturated signed result over a valid/ready handshake.
//
// Build option: define DOT_RELU_EN to clamp negative results to zero after
// saturation. out_sat still reports only the saturation step.
//
// ACC_WIDTH must be at least 2*DATA_WIDTH so a full product fits unclipped.

`timescale 1ns/1ps

module dot_product_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] weight,
  input  logic [DATA_WIDTH-1:0] act,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_FINISH,
    S_OUTPUT
  } state_e;

  // Saturation bounds expressed in accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e                       state_q,      state_d;
  logic [LEN_WIDTH-1:0]         len_q,        len_d;
  logic [DATA_WIDTH-1:0]        bias_q,       bias_d;
  logic [LEN_WIDTH-1:0]         cnt_q,        cnt_d;
  logic signed [ACC_WIDTH-1:0]  acc_q,        acc_d;
  logic signed [ACC_WIDTH-1:0]  prod_q,       prod_d;
  logic                         prod_vld_q,   prod_vld_d;
  logic [DATA_WIDTH-1:0]        out_data_q,   out_data_d;
  logic                         out_sat_q,    out_sat_d;
  logic                         out_valid_q,  out_valid_d;

  // ---------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------
  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    bias_ext;
  logic signed [ACC_WIDTH-1:0]    sum;
  logic                           xfer;
  logic                           last_xfer;
  logic [DATA_WIDTH-1:0]          sat_data;
  logic                           sat_flag;
  logic [DATA_WIDTH-1:0]          res_data;

  // Full-precision signed product, widened to the accumulator.
  assign prod_full = $signed(weight) * $signed(act);
  assign prod_ext  = ACC_WIDTH'(prod_full);
  assign bias_ext  = ACC_WIDTH'($signed(bias_q));
  assign sum       = acc_q + bias_ext;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready  = (state_q == S_ACCUM) && (cnt_q < len_q);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (cnt_q == len_q - LEN_WIDTH'(1));

  // Clip the biased sum to the signed output range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sat_data = sum[DATA_WIDTH-1:0];
    sat_flag = 1'b0;
    if (sum > SAT_MAX) begin
      sat_data = DATA_MAX;
      sat_flag = 1'b1;
    end else if (sum < SAT_MIN) begin
      sat_data = DATA_MIN;
      sat_flag = 1'b1;
    end
  end

`ifdef DOT_RELU_EN
  // Negative results clamp to zero; saturation flag is untouched.
  assign res_data = sat_data[DATA_WIDTH-1] ? '0 : sat_data;
`else
  assign res_data = sat_data;
`endif

  // ---------------------------------------------------------------------
  // Next-state, pipeline and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bias_d      = bias_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_vld_d  = xfer;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;

    // Stage 1 captures the product of the accepted pair.
    if (xfer) begin
      prod_d = prod_ext;
    end

    // Stage 2 folds the previous product into the accumulator (wrapping).
    if (prod_vld_q) begin
      acc_d = acc_q + prod_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = vec_len;
          bias_d = bias;
          cnt_d  = '0;
          acc_d  = '0;
          state_d = (vec_len == '0) ? S_FINISH : S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (xfer) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
        if (last_xfer) begin
          state_d = S_DRAIN;
        end
      end

      // Lets the final product land in the accumulator.
      S_DRAIN: begin
        state_d = S_FINISH;
      end

      S_FINISH: begin
        out_data_d  = res_data;
        out_sat_d   = sat_flag;
        out_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end

      // Result held stable until the consumer takes it.
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= S_IDLE;
      len_q       <= '0;
      bias_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine. The driver computes each expected
// result with plain 64-bit arithmetic and queues it; a monitor compares the
// queue head against the DUT whenever out_valid is high.

`timescale 1ns/1ps

module tb_dot_product_engine;

  typedef struct {
    logic [31:0] data;
    bit          sat;
    longint      cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  vec_len;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] weight;
  logic [31:0] act;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  exp_t   exp_q[$];
  int     w_arr[512];
  int     a_arr[512];
  int     stall_cycles = 0;
  bit     early_rdy    = 0;
  bit     prev_valid   = 0;

  dot_product_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec_len   (vec_len),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .weight    (weight),
    .act       (act),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: dot product plus bias in 64-bit wrapping arithmetic, then clip.
  task automatic model(input int len, input int b, output logic [31:0] d, output bit s);
    longint acc;
    acc = longint'(b);
    for (int i = 0; i < len; i++) acc += longint'(w_arr[i]) * longint'(a_arr[i]);
    s = 1'b0;
    if (acc > 64'sd2147483647) begin
      d = 32'h7FFF_FFFF;
      s = 1'b1;
    end else if (acc < -64'sd2147483648) begin
      d = 32'h8000_0000;
      s = 1'b1;
    end else begin
      d = acc[31:0];
    end
`ifdef DOT_RELU_EN
    if (d[31]) d = 32'h0;
`endif
  endtask

  // Consumer: ready after stall_cycles of valid, or held high early if asked.
  initial begin
    int age;
    age = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!out_valid) begin
        age = 0;
        out_ready = early_rdy;
      end else begin
        out_ready = (age >= stall_cycles);
        age++;
      end
    end
  end

  // Monitor: compare every valid cycle against the queue head, pop on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 64'(out_valid), 64'(0));
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0].data));
          check("out_sat", 64'(out_sat), 64'(exp_q[0].sat));
          if (!prev_valid) check("latency", 64'(cyc), 64'(exp_q[0].cyc));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // One dot product. gap_mode: 0 none, 1 alternate, 2 random. abort_after>=0
  // stops feeding after that many transfers and returns without waiting.
  task automatic run(input int len, input int b, input int gap_mode, input int stall,
                     input bit early, input bit poke, input int abort_after);
    logic [31:0] ed;
    bit          es;
    int          i;
    int          guard;
    exp_t        e;
    model(len, b, ed, es);
    stall_cycles = stall;
    early_rdy    = early;
    @(posedge clk);
    #1;
    start   = 1'b1;
    vec_len = 9'(len);
    bias    = b;
    if (len == 0) begin
      e.data = ed; e.sat = es; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    vec_len = 9'($urandom);
    bias    = $urandom;
    i = 0;
    guard = 0;
    while (i < len && !(abort_after >= 0 && i >= abort_after)) begin
      case (gap_mode)
        1:       in_valid = (guard % 2 == 0);
        2:       in_valid = 1'($urandom_range(0, 1));
        default: in_valid = 1'b1;
      endcase
      weight = w_arr[i];
      act    = a_arr[i];
      if (poke && guard == 2) begin
        start   = 1'b1;
        vec_len = 9'd5;
        bias    = 32'd999;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (i == len - 1) begin
          e.data = ed; e.sat = es; e.cyc = cyc + 3;
          exp_q.push_back(e);
        end
        i++;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      guard++;
      if (guard > 2000) begin
        check("feed_timeout", 64'(i), 64'(len));
        break;
      end
    end
    in_valid = 1'b0;
    if (abort_after < 0) begin
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
        @(negedge clk);
        if (len == 0) check("in_ready_len0", 64'(in_ready), 64'(0));
        guard++;
      end
      if (guard >= 500) begin
        check("result_timeout", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
      end
      @(posedge clk);
      #1;
      check("busy_after_handshake", 64'(busy), 64'(0));
      check("out_valid_after_handshake", 64'(out_valid), 64'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_out_sat"}, 64'(out_sat), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int len;
    int b;
    reset    = 1'b0;
    start    = 1'b0;
    vec_len  = '0;
    bias     = '0;
    in_valid = 1'b0;
    weight   = '0;
    act      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Back-to-back pairs: 10 + 10 - 18 + 28 = 30.
    w_arr[0] = 2;  a_arr[0] = 5;
    w_arr[1] = -3; a_arr[1] = 6;
    w_arr[2] = 4;  a_arr[2] = 7;
    run(3, 10, 0, 0, 0, 0, -1);

    // Positive and negative saturation.
    w_arr[0] = 32'h4000_0000; a_arr[0] = 32'h4000_0000;
    run(1, 0, 0, 1, 0, 0, -1);
    w_arr[0] = 32'h4000_0000; a_arr[0] = 32'hC000_0000;
    run(1, 0, 0, 0, 1, 0, -1);

    // Zero length: result is sat(bias), in_ready never raised.
    run(0, -7, 0, 0, 0, 0, -1);

    // Alternating in_valid, stalled consumer, ignored start during ACCUM.
    for (int k = 0; k < 4; k++) begin
      w_arr[k] = 1;
      a_arr[k] = 1;
    end
    run(4, 0, 1, 5, 0, 1, -1);

    // Reset after three of eight transfers aborts the run.
    for (int k = 0; k < 8; k++) begin
      w_arr[k] = k + 1;
      a_arr[k] = 2;
    end
    run(8, 5, 0, 0, 0, 0, 3);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    w_arr[0] = 3; a_arr[0] = 3;
    w_arr[1] = 1; a_arr[1] = 1;
    run(2, 0, 0, 0, 0, 0, -1);

    // ReLU boundary: -6 + 1 = -5.
    w_arr[0] = -2; a_arr[0] = 3;
    run(1, 1, 0, 0, 0, 0, -1);

    // Randomized runs mixing small values, full-range values and handshakes.
    for (int r = 0; r < 30; r++) begin
      len = (r == 29) ? 40 : int'($urandom_range(0, 12));
      for (int k = 0; k < len; k++) begin
        if (r % 3 == 0) begin
          w_arr[k] = $urandom;
          a_arr[k] = $urandom;
        end else begin
          w_arr[k] = int'($urandom_range(0, 200)) - 100;
          a_arr[k] = int'($urandom_range(0, 200)) - 100;
        end
      end
      b = (r % 4 == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
      run(len, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
